// File: rtl/pipe_pkg.sv
// Shared types and default widths for the pipeline stage register.
package pipe_pkg;

    // Occupancy of the stage: EMPTY (nothing held), BUSY (output register
    // valid), FULL (output register and skid slot both valid).
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    localparam int DATA_W_DEF = 32;
    localparam int CTRL_W_DEF = 8;
    localparam int CNT_W_DEF  = 16;

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry skid slot (control + payload + valid bit) that catches the beat
// accepted while the output register is stalled.
// Only built when PIPE_SKID_EN is defined.
`ifdef PIPE_SKID_EN
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [CTRL_W-1:0] wr_ctrl,
    input  logic [DATA_W-1:0] wr_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    // Slot storage: clear drops the entry and its control, payload is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (clr) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (wr_en) begin
            valid <= 1'b1;
            ctrl  <= wr_ctrl;
            data  <= wr_data;
        end else if (rd_en) begin
            valid <= 1'b0;
        end
    end

endmodule
`endif

// File: rtl/pipe_stage_hs.sv
// Generic pipeline stage register with valid/ready handshake, synchronous
// flush and a saturating count of flushes that discarded live entries.
// Build option PIPE_SKID_EN: registered in_ready backed by a skid slot;
// otherwise a single register with combinational in_ready.
//
// Handshake: a beat moves on a rising edge when valid and ready are both 1
// on that side; valid never depends on ready, and a presented output beat
// stays bit-stable until it is taken (or flushed).
module pipe_stage_hs
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  flush_cnt
);

    pipe_state_e       state_q, state_d;
    logic              rdy_q;
    logic              accept, deliver;
    logic              ld_in, ld_skid;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  cnt_q;

    assign out_valid = (state_q != EMPTY);
    assign out_ctrl  = ctrl_q;
    assign out_data  = data_q;
    assign flush_cnt = cnt_q;
    assign deliver   = out_valid && out_ready;
    // A beat offered during flush is dropped even if in_ready is high.
    assign accept    = in_valid && in_ready && !flush;

`ifdef PIPE_SKID_EN
    logic skid_wr;

    assign skid_wr  = (state_q == BUSY) && accept && !deliver;
    assign in_ready = rdy_q;

    // Registered ready: low in reset, then tracks "next state is not FULL".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_q <= 1'b0;
        else        rdy_q <= (state_d != FULL);
    end

    pipe_skid_buf #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (flush),
        .wr_en   (skid_wr),
        .rd_en   (ld_skid),
        .wr_ctrl (in_ctrl),
        .wr_data (in_data),
        .valid   (skid_valid),
        .ctrl    (skid_ctrl),
        .data    (skid_data)
    );
`else
    assign skid_valid = 1'b0;
    assign skid_ctrl  = '0;
    assign skid_data  = '0;
    assign in_ready   = rdy_q && (!out_valid || out_ready);

    // Ready enable: keeps in_ready low until the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_q <= 1'b0;
        else        rdy_q <= 1'b1;
    end
`endif

    // Occupancy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    // Next state and output-register load selects; flush overrides all.
    always_comb begin
        state_d = state_q;
        ld_in   = 1'b0;
        ld_skid = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        ld_in   = 1'b1;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    if (accept && deliver) begin
                        ld_in = 1'b1;
                    end else if (accept) begin
                        state_d = FULL;
                    end else if (deliver) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (deliver) begin
                        ld_skid = 1'b1;
                        state_d = BUSY;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Output register: flush zeroes control only; payload clears at reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
            data_q <= '0;
        end else if (flush) begin
            ctrl_q <= '0;
        end else if (ld_in) begin
            ctrl_q <= in_ctrl;
            data_q <= in_data;
        end else if (ld_skid) begin
            ctrl_q <= skid_ctrl;
            data_q <= skid_data;
        end
    end

    // Saturating count of flushes that killed at least one live entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (flush && (out_valid || skid_valid) && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: directed reset/stream/stall/flush vectors, a
// small-counter instance for saturation, then random traffic, all checked
// against an expected-beat queue popped by an output monitor.
module tb_pipe_stage_hs;

  localparam int W = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_ctrl = '0;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_ctrl;
  logic [31:0] out_data;
  logic [15:0] flush_cnt;

  logic        s_flush = 1'b0;
  logic        s_in_valid = 1'b0;
  logic        s_in_ready;
  logic [7:0]  s_out_ctrl;
  logic [31:0] s_out_data;
  logic        s_out_valid;
  logic [3:0]  s_flush_cnt;

  logic [W-1:0] exp_q[$];
  logic [15:0]  exp_cnt = '0;
  int           checks = 0;
  int           fails = 0;
  logic         hold_q = 1'b0;
  logic [W-1:0] held = '0;

  pipe_stage_hs dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .flush_cnt (flush_cnt)
  );

  pipe_stage_hs #(.CNT_W(4)) u_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (s_flush),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_ctrl   (8'h3C),
    .in_data   (32'h0000_0077),
    .out_valid (s_out_valid),
    .out_ready (1'b0),
    .out_ctrl  (s_out_ctrl),
    .out_data  (s_out_data),
    .flush_cnt (s_flush_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: called at posedge+1, returns at the following posedge+1
  task automatic step(input logic v, input logic [7:0] c, input logic [31:0] d,
                      input logic rdy, input logic fl, output logic acc);
    logic had;
    in_valid = v; in_ctrl = c; in_data = d; out_ready = rdy; flush = fl;
    had = (exp_q.size() != 0);
    @(negedge clk); #1;
    acc = v && in_ready && !fl;
    if (fl) begin
      exp_q.delete();
      if (had && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    end else if (acc) begin
      exp_q.push_back({c, d});
    end
    @(posedge clk); #1;
    chk("flush_cnt", flush_cnt, exp_cnt);
    if (fl) begin
      chk("flush_out_valid", out_valid, 0);
      chk("flush_out_ctrl", out_ctrl, 0);
    end
  endtask

  // monitor: pops and compares every delivered beat, checks stall stability
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_q = 1'b0;
    end else begin
      if (hold_q) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_beat", {out_ctrl, out_data}, held);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL beat: got unexpected 0x%0h expected none at %0t", {out_ctrl, out_data}, $time);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          if ({out_ctrl, out_data} !== e) begin
            fails++;
            $display("FAIL beat: got 0x%0h expected 0x%0h at %0t", {out_ctrl, out_data}, e, $time);
          end
        end
      end
      hold_q = out_valid && !out_ready && !flush;
      held = {out_ctrl, out_data};
    end
  end

  task automatic reset_checks(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_ctrl"}, out_ctrl, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_flush_cnt"}, flush_cnt, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
  endtask

  // reset asserted between edges; caller is at posedge+1
  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 reset_checks(tag);
    exp_q.delete();
    exp_cnt = '0;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_flush = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    #1 chk({tag, "_ready_before_edge"}, in_ready, 0);
    @(posedge clk); #1;
    chk({tag, "_ready_after_edge"}, in_ready, 1);
  endtask

  initial begin
    logic acc, sent;
    logic [31:0] d;

    // 1. power-on reset
    #2 reset_checks("por");
    @(negedge clk); rst_n = 1'b1;
    #1 chk("por_ready_before_edge", in_ready, 0);
    @(posedge clk); #1;
    chk("por_ready_after_edge", in_ready, 1);

    // 2. streaming, one beat per cycle, one cycle latency
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 8'hA5, 32'(k), 1'b1, 1'b0, acc);
      chk("stream_valid", out_valid, 1);
      chk("stream_data", out_data, 32'(k));
    end
    step(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, acc);
    chk("stream_drained", out_valid, 0);

    // 3. stall for 5 cycles holding 0xDEADBEEF, a second beat offered
    step(1'b1, 8'h5A, 32'hDEAD_BEEF, 1'b0, 1'b0, acc);
    sent = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(!sent, 8'h5A, 32'hCAFE_0001, 1'b0, 1'b0, acc);
      sent = sent | acc;
    end
    chk("stall_in_ready", in_ready, 0);
    chk("stall_out_data", out_data, 32'hDEAD_BEEF);
`ifdef PIPE_SKID_EN
    chk("stall_extra_beat", sent, 1);
`else
    chk("stall_extra_beat", sent, 0);
`endif
    for (int i = 0; i < 4; i++) begin
      step(!sent, 8'h5A, 32'hCAFE_0001, 1'b1, 1'b0, acc);
      sent = sent | acc;
    end
    chk("stall_all_delivered", exp_q.size(), 0);

    // 4. flush with a live entry; beat offered in the flush cycle dropped
    step(1'b1, 8'hFF, 32'h0000_1234, 1'b0, 1'b0, acc);
    step(1'b1, 8'h33, 32'h0000_5555, 1'b0, 1'b1, acc);
    chk("flush_cnt_one", flush_cnt, 1);
    chk("flush_data_held", out_data, 32'h0000_1234);
    step(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, acc);
    chk("flush_no_ghost", out_valid, 0);

    // 5. idle flush with in_ready high: beat dropped, count unchanged
    chk("idle_ready", in_ready, 1);
    step(1'b1, 8'h44, 32'h0000_6666, 1'b1, 1'b1, acc);
    chk("idle_flush_cnt", flush_cnt, 1);
    step(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, acc);
    chk("idle_no_beat", out_valid, 0);

    // 1b. reset in the middle of a stall with a nonzero counter
    step(1'b1, 8'h12, 32'h0000_ABCD, 1'b0, 1'b0, acc);
    do_reset("midrst");

    // 5b. saturation on the 4-bit counter instance: preload to 0xE
    for (int i = 0; i < 14; i++) begin
      s_in_valid = 1'b1; s_flush = 1'b0;
      @(posedge clk); #1;
      s_in_valid = 1'b0; s_flush = 1'b1;
      @(posedge clk); #1;
      s_flush = 1'b0;
    end
    chk("sat_preload", s_flush_cnt, 4'hE);
    for (int i = 0; i < 3; i++) begin
      s_in_valid = 1'b1; s_flush = 1'b0;
      @(posedge clk); #1;
      s_in_valid = 1'b0; s_flush = 1'b1;
      @(posedge clk); #1;
      s_flush = 1'b0;
      chk("sat_value", s_flush_cnt, 4'hF);
    end
    chk("sat_stage_empty", s_out_valid, 0);

    // 6. random traffic
    for (int i = 0; i < 10000; i++) begin
      d = $urandom;
      step(1'($urandom_range(0, 99) < 60), 8'($urandom_range(0, 255)), d,
           1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 99) < 5), acc);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, acc);
    chk("random_drained", exp_q.size(), 0);
    chk("random_out_valid", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
